// File: rtl/queue_fifo.sv
// ---------------------------------------------------------------------------
// queue_fifo
//
// Synchronous single-clock FIFO with first-word-fall-through read data.
// Status flags come straight from the registered occupancy count, so they
// are valid in the same cycle as the count they describe.
//
// Optional feature (compile-time macro):
//    QUEUE_FIFO_ERR_FLAGS_EN
//       defined   : sticky overflow/underflow flags, cleared by err_clr
//       undefined : ovf_err/unf_err tied to 0, err_clr ignored, and no
//                   error registers exist
//
// Parameters
//    DATA_WIDTH : bits per entry
//    DEPTH      : number of entries (power of two, >= 2)
//    AF_LEVEL   : almost_full  asserts when count >= AF_LEVEL
//    AE_LEVEL   : almost_empty asserts when count <= AE_LEVEL
//
// Ports
//    clk          : clock, all state changes on its rising edge
//    rst_n        : asynchronous active-low reset
//    push         : write request, accepted only when not full
//    push_data    : data to enqueue
//    pop          : read request, accepted only when not empty
//    pop_data     : oldest entry (zero-latency); 0 whenever empty
//    full         : count == DEPTH
//    empty        : count == 0
//    almost_full  : count >= AF_LEVEL
//    almost_empty : count <= AE_LEVEL
//    count        : number of valid entries, 0..DEPTH
//    err_clr      : clears the sticky error flags
//    ovf_err      : sticky, push attempted while full
//    unf_err      : sticky, pop attempted while empty
// ---------------------------------------------------------------------------
module queue_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = DEPTH - 2,
   parameter int AE_LEVEL   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [DATA_WIDTH-1:0]    push_data,
   input  logic                     pop,
   output logic [DATA_WIDTH-1:0]    pop_data,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [$clog2(DEPTH):0]   count,
   input  logic                     err_clr,
   output logic                     ovf_err,
   output logic                     unf_err
);

   // Pointer width indexes the storage; the count needs one extra bit so
   // that DEPTH itself is representable.
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [AW-1:0]         PTR_ZERO  = AW'(1'b0);
   localparam logic [AW-1:0]         PTR_ONE   = AW'(1'b1);
   localparam logic [CW-1:0]         CNT_ZERO  = CW'(1'b0);
   localparam logic [CW-1:0]         CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0]         CNT_DEPTH = CW'(DEPTH);
   localparam logic [CW-1:0]         CNT_AF    = CW'(AF_LEVEL);
   localparam logic [CW-1:0]         CNT_AE    = CW'(AE_LEVEL);
   localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];
   logic [AW-1:0]         wr_ptr_r;
   logic [AW-1:0]         rd_ptr_r;
   logic [CW-1:0]         count_r;

   // ------------------------------------------------------------------
   // Combinational control
   // ------------------------------------------------------------------
   logic                  full_s;
   logic                  empty_s;
   logic                  push_ok_s;
   logic                  pop_ok_s;
   logic [CW-1:0]         count_nxt_s;
   logic [AW-1:0]         wr_ptr_nxt_s;
   logic [AW-1:0]         rd_ptr_nxt_s;

   // Occupancy flags decoded from the registered count.
   always_comb begin
      full_s       = (count_r == CNT_DEPTH);
      empty_s      = (count_r == CNT_ZERO);
      full         = full_s;
      empty        = empty_s;
      almost_full  = (count_r >= CNT_AF);
      almost_empty = (count_r <= CNT_AE);
      count        = count_r;
   end

   // Request qualification. Gating pop with empty and push with full is
   // what makes push+pop at empty a push-only and push+pop at full a
   // pop-only operation.
   always_comb begin
      push_ok_s = push & ~full_s;
      pop_ok_s  = pop  & ~empty_s;
   end

   // Next pointer values; DEPTH is a power of two, so the natural
   // AW-bit rollover gives the DEPTH-1 -> 0 wrap.
   always_comb begin
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      if (push_ok_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
   end

   // Next count: a simultaneous accepted push and pop cancel out.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // First-word-fall-through read port. Forcing zero while empty keeps
   // stale storage (never cleared by reset) off the output.
   always_comb begin
      pop_data = DATA_ZERO;
      if (empty_s) begin
         pop_data = DATA_ZERO;
      end else begin
         pop_data = mem_r[rd_ptr_r];
      end
   end

   // ------------------------------------------------------------------
   // Sequential logic
   // ------------------------------------------------------------------

   // Pointer and count registers; reset discards all queued entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= PTR_ZERO;
         rd_ptr_r <= PTR_ZERO;
         count_r  <= CNT_ZERO;
      end else begin
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         count_r  <= count_nxt_s;
      end
   end

   // Storage write port; intentionally not reset so it maps onto RAM.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // ------------------------------------------------------------------
   // Sticky error flags
   // ------------------------------------------------------------------
`ifdef QUEUE_FIFO_ERR_FLAGS_EN
   logic ovf_err_r;
   logic unf_err_r;
   logic ovf_evt_s;
   logic unf_evt_s;

   // Error events are raw requests that the FIFO had to reject.
   always_comb begin
      ovf_evt_s = push & full_s;
      unf_evt_s = pop  & empty_s;
   end

   // Overflow flag: a new event wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_err_r <= 1'b0;
      end else if (ovf_evt_s) begin
         ovf_err_r <= 1'b1;
      end else if (err_clr) begin
         ovf_err_r <= 1'b0;
      end else begin
         ovf_err_r <= ovf_err_r;
      end
   end

   // Underflow flag: a new event wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unf_err_r <= 1'b0;
      end else if (unf_evt_s) begin
         unf_err_r <= 1'b1;
      end else if (err_clr) begin
         unf_err_r <= 1'b0;
      end else begin
         unf_err_r <= unf_err_r;
      end
   end

   assign ovf_err = ovf_err_r;
   assign unf_err = unf_err_r;
`else
   // Feature disabled: flags are constant and err_clr has no effect.
   logic unused_err_clr_s;
   assign unused_err_clr_s = err_clr;
   assign ovf_err          = 1'b0;
   assign unf_err          = 1'b0;
`endif

endmodule
